seg_scan_6digit: RTL

- Downstream display stage for the timer controller. It consumes the six BCD digits and the 2-bit timer_state and drives a multiplexed six-digit common-cathode/anode 7-segment module.
- It time-multiplexes the digits at the 1 kHz system clock and decodes BCD to segments.
- It adds a colon blink while the timer counts and a whole-display flash while ringing.
- Runs in the same clock domain as the controller and uses the same tick_1hz strobe.

---
 rtl/seg_scan_6digit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seg_scan_6digit.sv
// Six-digit multiplexed 7-segment scanner.
// Walks the six BCD digits one at a time, decodes each to segments, lights
// the colon dots while the timer runs (blinking on each second tick) and
// flashes the whole display while the timer rings. All outputs are registered,
// so the driven digit lags the internal scan index by one cycle.
module seg_scan_6digit #(
    parameter int DIGIT_HOLD     = 1,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic       clk_1k,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [1:0] timer_state,
    input  logic [3:0] h_tens,
    input  logic [3:0] h_ones,
    input  logic [3:0] m_tens,
    input  logic [3:0] m_ones,
    input  logic [3:0] s_tens,
    input  logic [3:0] s_ones,
    output logic [7:0] seg,
    output logic [5:0] com,
    output logic [2:0] scan_idx
);

    localparam logic [1:0] ST_RUNNING = 2'b10;
    localparam logic [1:0] ST_RINGING = 2'b11;
    localparam logic [7:0] HOLD_LAST  = 8'(DIGIT_HOLD - 1);
    localparam logic [5:0] COM_IDLE   = COM_ACTIVE_LOW ? 6'b111111 : 6'b000000;

    logic [2:0] idx_q,      idx_d;
    logic [7:0] hold_q,     hold_d;
    logic       colon_q,    colon_d;
    logic       blink_q,    blink_d;
    logic [7:0] seg_q,      seg_d;
    logic [5:0] com_q,      com_d;
    logic [2:0] scan_idx_q, scan_idx_d;

    logic [3:0] digit;
    logic [5:0] sel;

    // BCD to {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;
        endcase
    endfunction

    // Scan counter: hold each digit DIGIT_HOLD cycles, then step 0..5 and wrap.
    always_comb begin
        hold_d = hold_q + 8'd1;
        idx_d  = idx_q;
        if (hold_q == HOLD_LAST) begin
            hold_d = 8'd0;
            idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Colon and flash phases; the state sampled this cycle decides what a tick does.
    always_comb begin
        colon_d = 1'b1;
        blink_d = 1'b0;
        if (timer_state == ST_RUNNING) begin
            colon_d = tick_1hz ? ~colon_q : colon_q;
        end
        if (timer_state == ST_RINGING) begin
            blink_d = tick_1hz ? ~blink_q : blink_q;
        end
    end

    // Next segment/common pattern for the digit the scan index points at now.
    always_comb begin
        case (idx_q)
            3'd0:    digit = h_tens;
            3'd1:    digit = h_ones;
            3'd2:    digit = m_tens;
            3'd3:    digit = m_ones;
            3'd4:    digit = s_tens;
            3'd5:    digit = s_ones;
            default: digit = 4'd0;
        endcase

        sel        = 6'b000001 << idx_q;
        com_d      = COM_ACTIVE_LOW ? ~sel : sel;
        scan_idx_d = idx_q;

        seg_d = {1'b0, bcd_to_seg(digit)};
        if (colon_q && (idx_q == 3'd1 || idx_q == 3'd3)) begin
            seg_d[7] = 1'b1;
        end
        if (LZ_BLANK && idx_q == 3'd0 && h_tens == 4'd0) begin
            seg_d = 8'h00;
        end
        if (blink_q) begin
            seg_d = 8'h00;
        end
    end

    // State and output registers; reset wins over everything, including tick_1hz.
    always_ff @(posedge clk_1k) begin
        if (rst) begin
            idx_q      <= 3'd0;
            hold_q     <= 8'd0;
            colon_q    <= 1'b1;
            blink_q    <= 1'b0;
            seg_q      <= 8'h00;
            com_q      <= COM_IDLE;
            scan_idx_q <= 3'd0;
        end else begin
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            colon_q    <= colon_d;
            blink_q    <= blink_d;
            seg_q      <= seg_d;
            com_q      <= com_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign seg      = seg_q;
    assign com      = com_q;
    assign scan_idx = scan_idx_q;

endmodule
